deconv_dim1: RTL and testbench

Sequential 1-D binary deconvolver: the inverse of the team's combinational GF(2) convolver (`out = in * kernel` as polynomial product, bit index = degree, XOR accumulation). Given a convolved vector `y` and the `kernel` used to produce it, the block recovers `in` by long polynomial division over GF(2), one quotient bit per clock. It also reports whether the division was exact, which flags corrupted `y`. It sits on the receive side of the convolution path.

---
 rtl/deconv_dim1.sv | 169 ++++++++++++++++
 tb/tb_deconv_dim1.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/deconv_dim1.sv
// ---------------------------------------------------------------------------
// deconv_dim1
// Sequential 1-D GF(2) deconvolver. Recovers `in` from y = in * kernel
// (polynomial product over GF(2), bit index = degree) by long division,
// producing one quotient bit per clock, most significant degree first.
// Also reports whether the remainder was zero (y consistent with kernel)
// and whether the kernel's leading coefficient was zero (division undefined).
//
// Parameters
//   inlen      width of the recovered vector
//   kernlen    kernel width (>= 2)
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset, clears all outputs
//   start      request, sampled while idle or in the completion cycle
//   y_in       convolved vector (inlen+kernlen-1 bits), captured on start
//   kernel     kernel (kernlen bits), captured on start
//   busy       division in progress
//   done       one-cycle completion pulse
//   x_out      recovered quotient, held until the next completion
//   exact      remainder was zero; valid with and after done
//   err_kernel kernel MSB was zero; valid with and after done
// ---------------------------------------------------------------------------
module deconv_dim1 #(
   parameter int inlen   = 255,
   parameter int kernlen = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [inlen+kernlen-2:0] y_in,
   input  logic [kernlen-1:0]       kernel,
   output logic                     busy,
   output logic                     done,
   output logic [inlen-1:0]         x_out,
   output logic                     exact,
   output logic                     err_kernel
);

   localparam int YW = inlen + kernlen - 1;
   localparam int TW = (inlen > 1) ? $clog2(inlen) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DIV,
      S_FIN
   } state_t;

   state_t             r_state, w_state_next;
   logic [YW-1:0]      r_rem,   w_rem_next;
   logic [kernlen-1:0] r_k,     w_k_next;
   logic [TW-1:0]      r_t,     w_t_next;
   logic [inlen-1:0]   r_quo,   w_quo_next;
   logic               r_busy,  w_busy_next;
   logic               r_done,  w_done_next;
   logic [inlen-1:0]   r_x,     w_x_next;
   logic               r_exact, w_exact_next;
   logic               r_err,   w_err_next;

   // One division step at index t: the leading coefficient of the current
   // window R[t+kernlen-1 : t] is the quotient bit; when set, the kernel is
   // subtracted (XORed) from that window.
   logic [YW-1:0]    w_k_ext;
   logic [YW-1:0]    w_rem_shr;
   logic             w_q_bit;
   logic [YW-1:0]    w_rem_step;
   logic [inlen-1:0] w_quo_step;

   assign w_k_ext    = YW'(r_k);
   assign w_rem_shr  = r_rem >> r_t;
   assign w_q_bit    = w_rem_shr[kernlen-1];
   assign w_rem_step = w_q_bit ? (r_rem ^ (w_k_ext << r_t)) : r_rem;
   // t counts down from inlen-1, so shifting bits in from the right leaves
   // each quotient bit at its own degree once all steps are done.
   assign w_quo_step = {r_quo[inlen-2:0], w_q_bit};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_rem   <= '0;
         r_k     <= '0;
         r_t     <= '0;
         r_quo   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_x     <= '0;
         r_exact <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_rem   <= w_rem_next;
         r_k     <= w_k_next;
         r_t     <= w_t_next;
         r_quo   <= w_quo_next;
         r_busy  <= w_busy_next;
         r_done  <= w_done_next;
         r_x     <= w_x_next;
         r_exact <= w_exact_next;
         r_err   <= w_err_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_rem_next   = r_rem;
      w_k_next     = r_k;
      w_t_next     = r_t;
      w_quo_next   = r_quo;
      w_busy_next  = r_busy;
      w_done_next  = 1'b0;
      w_x_next     = r_x;
      w_exact_next = r_exact;
      w_err_next   = r_err;

      case (r_state)
         // FIN is the cycle in which done is high. A start arriving in it is
         // taken exactly like one in IDLE, so back-to-back requests issued
         // alongside done give one result every inlen+1 cycles.
         S_IDLE, S_FIN: begin
            w_busy_next  = 1'b0;
            w_state_next = S_IDLE;
            if (start) begin
               w_rem_next = y_in;
               w_k_next   = kernel;
               w_t_next   = TW'(inlen - 1);
               w_quo_next = '0;
               if (!kernel[kernlen-1]) begin
                  w_state_next = S_FIN;
                  w_done_next  = 1'b1;
                  w_x_next     = '0;
                  w_exact_next = 1'b0;
                  w_err_next   = 1'b1;
               end else begin
                  w_state_next = S_DIV;
                  w_busy_next  = 1'b1;
               end
            end
         end

         S_DIV: begin
            w_rem_next = w_rem_step;
            w_quo_next = w_quo_step;
            w_t_next   = r_t - TW'(1);
            // The last step publishes its own result in the same edge so
            // that done follows the start by exactly inlen cycles.
            if (r_t == '0) begin
               w_state_next = S_FIN;
               w_busy_next  = 1'b0;
               w_done_next  = 1'b1;
               w_x_next     = w_quo_step;
               w_exact_next = (w_rem_step[kernlen-2:0] == '0);
               w_err_next   = 1'b0;
            end
         end

         default: begin
            w_state_next = S_IDLE;
            w_busy_next  = 1'b0;
         end
      endcase
   end

   assign busy       = r_busy;
   assign done       = r_done;
   assign x_out      = r_x;
   assign exact      = r_exact;
   assign err_kernel = r_err;

endmodule

// File: tb/tb_deconv_dim1.sv
// ---------------------------------------------------------------------------
// tb_deconv_dim1
// Self-checking bench for deconv_dim1. A small instance (inlen=8) runs the
// directed cases; a default instance (255/3) runs randomised round trips
// against a GF(2) convolution model with back-to-back starts. Expected
// results are queued when a request is driven and compared on each done.
// ---------------------------------------------------------------------------
module tb_deconv_dim1;

   localparam int BL = 255;
   localparam int BK = 3;
   localparam int BY = BL + BK - 1;
   localparam int NT = 200;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic       s_start;
   logic [9:0] s_y;
   logic [2:0] s_k;
   logic       s_busy, s_done, s_exact, s_err;
   logic [7:0] s_x;

   logic          b_start;
   logic [BY-1:0] b_y;
   logic [BK-1:0] b_k;
   logic          b_busy, b_done, b_exact, b_err;
   logic [BL-1:0] b_x;

   deconv_dim1 #(.inlen(8), .kernlen(3)) u_s (
      .clk(clk), .rst(rst), .start(s_start), .y_in(s_y), .kernel(s_k),
      .busy(s_busy), .done(s_done), .x_out(s_x), .exact(s_exact),
      .err_kernel(s_err)
   );

   deconv_dim1 u_b (
      .clk(clk), .rst(rst), .start(b_start), .y_in(b_y), .kernel(b_k),
      .busy(b_busy), .done(b_done), .x_out(b_x), .exact(b_exact),
      .err_kernel(b_err)
   );

   typedef struct {
      logic [255:0] x;
      logic         exact;
      logic         err;
   } exp_t;

   exp_t s_q[$];
   exp_t b_q[$];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_val(input string tag, input logic [255:0] got,
                            input logic [255:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference convolver: y = a * k over GF(2).
   function automatic logic [BY-1:0] conv(input logic [BL-1:0] a,
                                          input logic [BK-1:0] k);
      logic [BY-1:0] y = '0;
      for (int i = 0; i < BK; i++)
         if (k[i]) y ^= (BY'(a) << i);
      return y;
   endfunction

   // Result monitors: one line per completed transaction.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && s_done) begin
         if (s_q.size() == 0) begin
            check_val("s_unexpected_done", 1, 0);
         end else begin
            e = s_q.pop_front();
            $display("s txn: x=%0h exact=%0b err=%0b (exp %0h/%0b/%0b)",
                     s_x, s_exact, s_err, e.x, e.exact, e.err);
            check_val("s_x", s_x, e.x);
            check_val("s_exact", s_exact, e.exact);
            check_val("s_err", s_err, e.err);
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (!rst && b_done) begin
         if (b_q.size() == 0) begin
            check_val("b_unexpected_done", 1, 0);
         end else begin
            e = b_q.pop_front();
            $display("b txn: x=%0h exact=%0b err=%0b", b_x, b_exact, b_err);
            check_val("rt_x", b_x, e.x);
            check_val("rt_exact", b_exact, e.exact);
            check_val("rt_err", b_err, e.err);
         end
      end
   end

   // Issue one request on the small instance and follow it to done.
   // glitch_at > 0 pulses a conflicting start that many cycles into the run.
   task automatic s_run(input logic [9:0] y, input logic [2:0] k,
                        input logic [7:0] ex_x, input logic ex_exact,
                        input logic ex_err, input int glitch_at,
                        input string tag);
      exp_t e;
      int   lat;
      int   busy_cnt;
      e.x = 256'(ex_x); e.exact = ex_exact; e.err = ex_err;
      s_y = y; s_k = k; s_start = 1'b1;
      s_q.push_back(e);
      lat = 0; busy_cnt = 0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         s_start = 1'b0;
         s_y = ~y; s_k = ~k;
         if (n == glitch_at) begin
            s_start = 1'b1;
            s_y = 10'h01B;
            s_k = 3'b111;
         end
         if (s_busy) busy_cnt++;
         if (s_done) begin
            lat = n;
            break;
         end
      end
      check_val({tag, "_done_cycle"}, lat, ex_err ? 1 : 9);
      check_val({tag, "_busy_cycles"}, busy_cnt, ex_err ? 0 : 8);
      @(negedge clk);
      check_val({tag, "_done_one_cycle"}, s_done, 0);
   endtask

   task automatic b_issue();
      logic [255:0] tmp;
      int           r;
      exp_t         e;
      for (int w = 0; w < 8; w++) tmp[w*32 +: 32] = $urandom();
      tmp[255] = 1'b0;
      r = $urandom_range(0, 3);
      b_k = {1'b1, r[1:0]};
      b_y = conv(tmp[BL-1:0], b_k);
      e.x = tmp; e.exact = 1'b1; e.err = 1'b0;
      b_q.push_back(e);
      b_start = 1'b1;
   endtask

   initial begin
      int dcnt;
      int issued;
      int b_dn;
      bit pend;

      rst = 1'b1;
      s_start = 1'b0; s_y = '0; s_k = '0;
      b_start = 1'b0; b_y = '0; b_k = '0;
      repeat (2) @(negedge clk);
      check_val("rst_s_outs", {s_busy, s_done, s_x, s_exact, s_err}, 0);
      check_val("rst_b_outs", {b_busy, b_done, b_x, b_exact, b_err}, 0);
      rst = 1'b0;
      @(negedge clk);

      s_run(10'b00_0001_1011, 3'b111, 8'h05, 1'b1, 1'b0, 0, "exact");
      s_run(10'b00_0001_1010, 3'b111, 8'h05, 1'b0, 1'b0, 0, "corrupt");
      s_run(10'h294,          3'b100, 8'hA5, 1'b1, 1'b0, 0, "shift");

      // Reset four cycles into a division.
      s_y = 10'h01B; s_k = 3'b111; s_start = 1'b1;
      @(negedge clk);
      s_start = 1'b0;
      repeat (3) @(negedge clk);
      check_val("mid_div_busy", s_busy, 1);
      rst = 1'b1;
      #1;
      check_val("rst_mid_busy", s_busy, 0);
      check_val("rst_mid_done", s_done, 0);
      check_val("rst_mid_x", s_x, 0);
      check_val("rst_mid_exact", s_exact, 0);
      check_val("rst_mid_err", s_err, 0);
      @(negedge clk);
      rst = 1'b0;
      dcnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (s_done) dcnt++;
      end
      check_val("rst_no_done", dcnt, 0);

      s_run(10'h294, 3'b100, 8'hA5, 1'b1, 1'b0, 3, "ignored_start");
      s_run(10'h3FF, 3'b011, 8'h00, 1'b0, 1'b1, 0, "kernel_err");

      // Round trips with a new start issued in every done cycle.
      issued = 1; b_dn = 0; pend = 1'b1;
      b_issue();
      for (int c = 0; c < 60000; c++) begin
         @(negedge clk);
         b_start = 1'b0;
         if (pend) begin
            check_val("b_accept", b_busy, 1);
            pend = 1'b0;
         end
         if (b_done) begin
            b_dn++;
            if (issued < NT) begin
               b_issue();
               issued++;
               pend = 1'b1;
            end
         end
         if (b_dn == NT) break;
      end
      check_val("b_results", b_dn, NT);
      @(negedge clk);
      check_val("s_queue_left", s_q.size(), 0);
      check_val("b_queue_left", b_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
